// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one PC in flight, single-beat memory read,
// {inst, pc, fault} handed to decode; flush kills the fetch in flight.
module ifu_fetch #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = 32'h80000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pc_valid,
  input  logic [DATA_WIDTH-1:0] pc_in,
  output logic                  pc_ready,
  input  logic                  flush,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [DATA_WIDTH-1:0] req_addr,
  input  logic                  rsp_valid,
  input  logic [DATA_WIDTH-1:0] rsp_data,
  input  logic                  rsp_err,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [DATA_WIDTH-1:0] inst_pc,
  output logic                  inst_fault
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    OUT
  } state_t;

  state_t                state_q, state_d;
  logic                  drop_q, drop_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] inst_q, inst_d;
  logic [DATA_WIDTH-1:0] ipc_q, ipc_d;
  logic                  fault_q, fault_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      drop_q  <= 1'b0;
      pc_q    <= RESET_VAL;
      inst_q  <= '0;
      ipc_q   <= RESET_VAL;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    drop_d     = drop_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    ipc_d      = ipc_q;
    fault_d    = fault_q;
    pc_ready   = 1'b0;
    req_valid  = 1'b0;
    inst_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        pc_ready = !flush;
        if (pc_valid && !flush) begin
          pc_d = pc_in;
          // Misaligned PCs never reach the bus; they retire as a fault.
          if (pc_in[1:0] != 2'b00) begin
            state_d = OUT;
            inst_d  = '0;
            fault_d = 1'b1;
            ipc_d   = pc_in;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        req_valid = 1'b1;
        if (flush) drop_d = 1'b1;
        if (req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (rsp_valid) begin
          if (drop_q || flush) begin
            drop_d  = 1'b0;
            state_d = IDLE;
          end else begin
            inst_d  = rsp_err ? '0 : rsp_data;
            fault_d = rsp_err;
            ipc_d   = pc_q;
            state_d = OUT;
          end
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      OUT: begin
        inst_valid = 1'b1;
        if (flush || inst_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_addr   = pc_q;
  assign inst       = inst_q;
  assign inst_pc    = ipc_q;
  assign inst_fault = fault_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed cycle table, then random traffic
// checked against a fetch-transaction model.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_valid;
  logic [31:0] pc_in;
  logic        pc_ready;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;

  ifu_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .pc_valid  (pc_valid),
    .pc_in     (pc_in),
    .pc_ready  (pc_ready),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst      (inst),
    .inst_pc   (inst_pc),
    .inst_fault(inst_fault)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        pv;
    logic [31:0] pc;
    logic        fl;
    logic        rqr;
    logic        rsv;
    logic [31:0] rd;
    logic        re;
    logic        ir;
    logic        e_pr;
    logic        e_rv;
    logic [31:0] e_ra;
    logic        e_iv;
    logic [31:0] e_i;
    logic [31:0] e_ip;
    logic        e_f;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(
    logic pv, logic [31:0] pc, logic fl, logic rqr, logic rsv,
    logic [31:0] rd, logic re, logic ir, logic pr, logic rv,
    logic [31:0] ra, logic iv, logic [31:0] i, logic [31:0] ip,
    logic f);
    vec_t r;
    r.pv = pv; r.pc = pc; r.fl = fl; r.rqr = rqr; r.rsv = rsv;
    r.rd = rd; r.re = re; r.ir = ir; r.e_pr = pr; r.e_rv = rv;
    r.e_ra = ra; r.e_iv = iv; r.e_i = i; r.e_ip = ip; r.e_f = f;
    return r;
  endfunction

  // transaction model of the single outstanding fetch
  logic        busy, open, mis, req_done, responded, rerr;
  logic [31:0] mpc, rdata;
  logic        mem_pend;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          nret = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h00c0ffee;
  endfunction

  task automatic idle_in();
    pc_valid = 0; pc_in = 0; flush = 0; req_ready = 0;
    rsp_valid = 0; rsp_data = 0; rsp_err = 0; inst_ready = 0;
  endtask

  task automatic rnd_cycle(input bit drain);
    logic        e_pr, e_rv, e_iv;
    logic [31:0] e_i;
    @(posedge clk);
    #1;
    if (drain) begin
      pc_valid = 0; flush = 0; req_ready = 1; inst_ready = 1;
    end else begin
      pc_valid   = $urandom_range(0, 9) < 7;
      pc_in      = {$urandom} & 32'hffff_fffc;
      if ($urandom_range(0, 7) == 0) pc_in[1:0] = 2'($urandom_range(1, 3));
      flush      = $urandom_range(0, 11) == 0;
      req_ready  = $urandom_range(0, 9) < 6;
      inst_ready = $urandom_range(0, 9) < 6;
    end
    rsp_valid = 0;
    rsp_data  = $urandom;
    rsp_err   = 1'($urandom_range(0, 1));
    if (mem_pend) begin
      if (mem_cnt == 0) begin
        rsp_valid = 1;
        rsp_data  = memf(mem_addr);
        rsp_err   = drain ? 1'b0 : ($urandom_range(0, 4) == 0);
        mem_pend  = 0;
      end else begin
        mem_cnt--;
      end
    end
    @(negedge clk);
    e_pr = !busy && !flush;
    e_rv = busy && !mis && !req_done;
    e_iv = open && (mis || responded);
    e_i  = (mis || rerr) ? 32'h0 : rdata;
    chk("rnd pc_ready", pc_ready, e_pr);
    chk("rnd req_valid", req_valid, e_rv);
    chk("rnd req_addr", req_addr, mpc);
    chk("rnd inst_valid", inst_valid, e_iv);
    if (e_iv) begin
      chk("rnd inst", inst, e_i);
      chk("rnd inst_pc", inst_pc, mpc);
      chk("rnd inst_fault", inst_fault, mis || rerr);
    end
    if (e_rv && req_ready) begin
      req_done = 1; mem_pend = 1;
      mem_cnt  = $urandom_range(0, 2);
      mem_addr = mpc;
    end
    if (rsp_valid && busy && req_done && !responded) begin
      responded = 1; rdata = rsp_data; rerr = rsp_err;
      if (!open) busy = 0;
    end
    if (e_iv && inst_ready && !flush) begin
      open = 0; busy = 0; nret++;
    end
    if (open && flush) begin
      open = 0;
      if (mis || responded) busy = 0;
    end
    if (e_pr && pc_valid) begin
      busy = 1; open = 1; mpc = pc_in;
      mis = pc_in[1:0] != 2'b00;
      req_done = 0; responded = 0;
    end
  endtask

  initial begin
    idle_in();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("rst pc_ready", pc_ready, 1'b1);
    chk("rst req_valid", req_valid, 1'b0);
    chk("rst req_addr", req_addr, 32'h80000000);
    chk("rst inst_valid", inst_valid, 1'b0);
    chk("rst inst", inst, 32'h0);
    chk("rst inst_pc", inst_pc, 32'h80000000);
    chk("rst inst_fault", inst_fault, 1'b0);

    // basic fetch
    tbl.push_back(v(1,32'h80000000,0,0,0,0,0,0, 1,0,32'h80000000,0,0,32'h80000000,0));
    tbl.push_back(v(0,0,0,1,0,0,0,0, 0,1,32'h80000000,0,0,32'h80000000,0));
    tbl.push_back(v(0,0,0,0,1,32'h413,0,0, 0,0,32'h80000000,0,0,32'h80000000,0));
    tbl.push_back(v(0,0,0,0,0,0,0,1, 0,0,32'h80000000,1,32'h413,32'h80000000,0));
    // request stalled five cycles
    tbl.push_back(v(1,32'h80000010,0,0,0,0,0,0, 1,0,32'h80000000,0,32'h413,32'h80000000,0));
    for (int k = 0; k < 5; k++)
      tbl.push_back(v(1,32'h80000080,0,0,0,0,0,0, 0,1,32'h80000010,0,32'h413,32'h80000000,0));
    tbl.push_back(v(0,0,0,1,0,0,0,0, 0,1,32'h80000010,0,32'h413,32'h80000000,0));
    tbl.push_back(v(0,0,0,0,1,32'h13,0,0, 0,0,32'h80000010,0,32'h413,32'h80000000,0));
    tbl.push_back(v(0,0,0,0,0,0,0,1, 0,0,32'h80000010,1,32'h13,32'h80000010,0));
    // flush in WAIT, stale response dropped
    tbl.push_back(v(1,32'h80000020,0,0,0,0,0,0, 1,0,32'h80000010,0,32'h13,32'h80000010,0));
    tbl.push_back(v(0,0,0,1,0,0,0,0, 0,1,32'h80000020,0,32'h13,32'h80000010,0));
    tbl.push_back(v(0,0,1,0,0,0,0,0, 0,0,32'h80000020,0,32'h13,32'h80000010,0));
    tbl.push_back(v(0,0,0,0,1,32'hdeadbeef,0,0, 0,0,32'h80000020,0,32'h13,32'h80000010,0));
    tbl.push_back(v(0,0,0,0,0,0,0,1, 1,0,32'h80000020,0,32'h13,32'h80000010,0));
    // misaligned PC
    tbl.push_back(v(1,32'h80000002,0,0,0,0,0,0, 1,0,32'h80000020,0,32'h13,32'h80000010,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0, 0,0,32'h80000002,1,0,32'h80000002,1));
    tbl.push_back(v(0,0,0,0,0,0,0,1, 0,0,32'h80000002,1,0,32'h80000002,1));
    // bus error, decode stalls three cycles
    tbl.push_back(v(1,32'h80000030,0,0,0,0,0,0, 1,0,32'h80000002,0,0,32'h80000002,1));
    tbl.push_back(v(0,0,0,1,0,0,0,0, 0,1,32'h80000030,0,0,32'h80000002,1));
    tbl.push_back(v(0,0,0,0,1,32'h12345678,1,0, 0,0,32'h80000030,0,0,32'h80000002,1));
    for (int k = 0; k < 3; k++)
      tbl.push_back(v(0,0,0,0,0,0,0,0, 0,0,32'h80000030,1,0,32'h80000030,1));
    tbl.push_back(v(0,0,0,0,0,0,0,1, 0,0,32'h80000030,1,0,32'h80000030,1));
    // flush together with inst_ready in OUT
    tbl.push_back(v(1,32'h80000040,0,0,0,0,0,0, 1,0,32'h80000030,0,0,32'h80000030,1));
    tbl.push_back(v(0,0,0,1,0,0,0,0, 0,1,32'h80000040,0,0,32'h80000030,1));
    tbl.push_back(v(0,0,0,0,1,32'h0badc0de,0,0, 0,0,32'h80000040,0,0,32'h80000030,1));
    tbl.push_back(v(0,0,1,0,0,0,0,1, 0,0,32'h80000040,1,32'h0badc0de,32'h80000040,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0, 1,0,32'h80000040,0,32'h0badc0de,32'h80000040,0));
    // flush in IDLE blocks a coincident PC
    tbl.push_back(v(1,32'h80000050,1,0,0,0,0,0, 0,0,32'h80000040,0,32'h0badc0de,32'h80000040,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0, 1,0,32'h80000040,0,32'h0badc0de,32'h80000040,0));
    // flush in REQ: request still completes, response dropped
    tbl.push_back(v(1,32'h80000060,0,0,0,0,0,0, 1,0,32'h80000040,0,32'h0badc0de,32'h80000040,0));
    tbl.push_back(v(0,0,1,0,0,0,0,0, 0,1,32'h80000060,0,32'h0badc0de,32'h80000040,0));
    tbl.push_back(v(0,0,0,1,0,0,0,0, 0,1,32'h80000060,0,32'h0badc0de,32'h80000040,0));
    tbl.push_back(v(0,0,0,0,1,32'h11111111,0,0, 0,0,32'h80000060,0,32'h0badc0de,32'h80000040,0));
    tbl.push_back(v(0,0,0,0,0,0,0,1, 1,0,32'h80000060,0,32'h0badc0de,32'h80000040,0));

    for (int k = 0; k < tbl.size(); k++) begin
      @(posedge clk);
      #1;
      pc_valid  = tbl[k].pv;  pc_in    = tbl[k].pc;
      flush     = tbl[k].fl;  req_ready = tbl[k].rqr;
      rsp_valid = tbl[k].rsv; rsp_data = tbl[k].rd;
      rsp_err   = tbl[k].re;  inst_ready = tbl[k].ir;
      @(negedge clk);
      chk($sformatf("tbl%0d pc_ready", k), pc_ready, tbl[k].e_pr);
      chk($sformatf("tbl%0d req_valid", k), req_valid, tbl[k].e_rv);
      chk($sformatf("tbl%0d req_addr", k), req_addr, tbl[k].e_ra);
      chk($sformatf("tbl%0d inst_valid", k), inst_valid, tbl[k].e_iv);
      chk($sformatf("tbl%0d inst", k), inst, tbl[k].e_i);
      chk($sformatf("tbl%0d inst_pc", k), inst_pc, tbl[k].e_ip);
      chk($sformatf("tbl%0d inst_fault", k), inst_fault, tbl[k].e_f);
    end

    busy = 0; open = 0; mis = 0; req_done = 0; responded = 0;
    rerr = 0; rdata = 0; mpc = 32'h80000060;
    mem_pend = 0; mem_cnt = 0; mem_addr = 0;
    for (int k = 0; k < 3000; k++) rnd_cycle(1'b0);
    for (int k = 0; k < 20; k++) rnd_cycle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
